// File: rtl/float_div.sv
// rtl/float_div.sv - multi-cycle floating-point divider (restoring mantissa division)
// Purpose: divides op1 by op2 in the float_pack format (bias 2^(N_exposant-1)-1,
//          implicit leading one, exponent 0 means zero, no denormals/NaN/Inf).
//          Fixed latency: done pulses N_mantisse+3 edges after the start edge.
// Ports:
//   clk      - single clock, rising edge
//   reset    - synchronous active-high reset
//   start    - operation request, sampled only while idle
//   op1/op2  - dividend / divisor, packed {sign, exponent, mantissa}
//   busy     - operation in flight (includes the done cycle)
//   done     - one-cycle pulse, result and div_zero valid
//   result   - quotient, held until the next done
//   div_zero - divisor was zero, updated with done
module float_div #(
  parameter int N_mantisse = 23,
  parameter int N_exposant = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [N_exposant+N_mantisse:0] op1,
  input  logic [N_exposant+N_mantisse:0] op2,
  output logic                           busy,
  output logic                           done,
  output logic [N_exposant+N_mantisse:0] result,
  output logic                           div_zero
);

  localparam int W  = 1 + N_exposant + N_mantisse;
  localparam int QW = N_mantisse + 2;          // quotient bits: 1 integer + N_mantisse+1 fraction
  localparam int CW = $clog2(QW + 1);
  localparam int EW = N_exposant + 2;          // signed exponent arithmetic width

  localparam logic [EW-1:0]         D_E   = EW'((1 << (N_exposant - 1)) - 1);
  localparam logic [EW-1:0]         E_TOP = EW'((1 << N_exposant) - 2);
  localparam logic [N_exposant-1:0] E_SAT = N_exposant'((1 << N_exposant) - 2);

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_NORM} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_sign;
  logic [N_exposant-1:0]   r_e1;
  logic [N_exposant-1:0]   r_e2;
  logic [N_mantisse:0]     r_div;
  logic [QW-1:0]           r_rem;
  logic [QW-1:0]           r_quo;
  logic [CW-1:0]           r_cnt;
  logic                    r_done;
  logic [W-1:0]            r_result;
  logic                    r_div_zero;

  logic [QW-1:0]           w_dsr;
  logic                    w_ge;
  logic [QW-1:0]           w_keep;
  logic [QW-1:0]           w_rem_next;
  logic                    w_shift;
  logic [N_mantisse-1:0]   w_mant;
  logic [EW-1:0]           w_exp;
  logic [W-1:0]            w_res;
  logic                    w_dz;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_DIVIDE;
      S_DIVIDE: if (r_cnt == CW'(QW - 1)) w_next = S_NORM;
      S_NORM:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // One restoring-division step: the partial remainder stays below twice the
  // divisor, so QW bits are enough to hold it after the left shift.
  always_comb begin
    w_dsr      = {1'b0, r_div};
    w_ge       = (r_rem >= w_dsr);
    w_keep     = w_ge ? (r_rem - w_dsr) : r_rem;
    w_rem_next = {w_keep[QW-2:0], 1'b0};
  end

  // Normalisation and special cases. Quotient lies in [0.5, 2): if the integer
  // bit is clear the leading one sits one position lower and the exponent drops.
  always_comb begin
    w_shift = ~r_quo[QW-1];
    w_mant  = r_quo[QW-1] ? r_quo[QW-2:1] : r_quo[QW-3:0];
    w_exp   = {2'b00, r_e1} - {2'b00, r_e2} + D_E - {{(EW-1){1'b0}}, w_shift};
    w_dz    = 1'b0;
    if (r_e2 == '0) begin
      w_res = {r_sign, E_SAT, {N_mantisse{1'b1}}};
      w_dz  = 1'b1;
    end else if ((r_e1 == '0) || w_exp[EW-1] || (w_exp == '0)) begin
      w_res = {r_sign, {(W-1){1'b0}}};
    end else if (w_exp > E_TOP) begin
      w_res = {r_sign, E_SAT, {N_mantisse{1'b1}}};
    end else begin
      w_res = {r_sign, w_exp[N_exposant-1:0], w_mant};
    end
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done     <= 1'b0;
      r_result   <= '0;
      r_div_zero <= 1'b0;
      r_cnt      <= '0;
      r_sign     <= 1'b0;
      r_e1       <= '0;
      r_e2       <= '0;
      r_div      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sign <= op1[W-1] ^ op2[W-1];
            r_e1   <= op1[W-2:N_mantisse];
            r_e2   <= op2[W-2:N_mantisse];
            r_div  <= {1'b1, op2[N_mantisse-1:0]};
            r_rem  <= {1'b0, 1'b1, op1[N_mantisse-1:0]};
            r_quo  <= '0;
            r_cnt  <= '0;
          end
        end
        S_DIVIDE: begin
          r_rem <= w_rem_next;
          r_quo <= {r_quo[QW-2:0], w_ge};
          r_cnt <= r_cnt + CW'(1);
        end
        S_NORM: begin
          r_result   <= w_res;
          r_div_zero <= w_dz;
          r_done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE) || r_done;
  assign done     = r_done;
  assign result   = r_result;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_float_div.sv
// tb/tb_float_div.sv - self-checking bench for float_div (single precision)
module tb_float_div;

  localparam int NM  = 23;
  localparam int NE  = 8;
  localparam int LAT = NM + 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_zero;

  float_div #(.N_mantisse(NM), .N_exposant(NE)) dut (
    .clk(clk), .reset(reset), .start(start), .op1(op1), .op2(op2),
    .busy(busy), .done(done), .result(result), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
  endtask

  // Reference: quotient of the significands as one integer division, then
  // normalise, truncate and apply the special cases.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic dz);
    logic   s;
    int     ea, eb, e;
    longint na, nb, q;
    logic [22:0] m;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    dz = 1'b0;
    if (eb == 0) begin
      r  = {s, 8'hFE, 23'h7FFFFF};
      dz = 1'b1;
      return;
    end
    if (ea == 0) begin
      r = {s, 31'b0};
      return;
    end
    na = longint'({1'b1, a[22:0]});
    nb = longint'({1'b1, b[22:0]});
    q  = (na << 24) / nb;
    e  = ea - eb + 127;
    if (q >= (longint'(1) << 24)) m = 23'((q >> 1) & 64'h7FFFFF);
    else begin
      m = 23'(q & 64'h7FFFFF);
      e = e - 1;
    end
    if (e < 1)        r = {s, 31'b0};
    else if (e > 254) r = {s, 8'hFE, 23'h7FFFFF};
    else              r = {s, 8'(e), m};
  endfunction

  // Transaction model: which starts are accepted and when done is due
  bit          pend     = 1'b0;
  int          exp_due  = 0;
  logic [31:0] exp_res  = '0;
  logic        exp_dz   = 1'b0;
  logic [31:0] last_res = '0;
  logic        last_dz  = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      pend     = 1'b0;
      last_res = '0;
      last_dz  = 1'b0;
    end else if (start && !(pend && exp_due >= cyc)) begin
      pend    = 1'b1;
      exp_due = cyc + LAT;
      model(op1, op2, exp_res, exp_dz);
    end
  end

  // Output compare, every cycle
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (pend && cyc == exp_due) begin
        chk("done_pulse", {31'b0, done}, 32'd1);
        chk("model_result", result, exp_res);
        chk("model_div_zero", {31'b0, div_zero}, {31'b0, exp_dz});
        last_res = exp_res;
        last_dz  = exp_dz;
      end else begin
        chk("done_quiet", {31'b0, done}, 32'd0);
        chk("result_held", result, last_res);
        chk("div_zero_held", {31'b0, div_zero}, {31'b0, last_dz});
      end
      if (pend && cyc >= exp_due - LAT + 1 && cyc <= exp_due)
        chk("busy_high", {31'b0, busy}, 32'd1);
      else if (!pend || cyc > exp_due)
        chk("busy_low", {31'b0, busy}, 32'd0);
    end
  end

  task automatic wait_done(input string nm, input int t0,
                           input logic [31:0] er, input logic edz);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    chk({nm, "_done_seen"}, {31'b0, seen}, 32'd1);
    if (seen) begin
      chk({nm, "_latency"}, 32'(cyc - t0), 32'(LAT));
      chk({nm, "_result"}, result, er);
      chk({nm, "_div_zero"}, {31'b0, div_zero}, {31'b0, edz});
    end
  endtask

  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic edz);
    int t0;
    @(negedge clk);
    op1 = a; op2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    wait_done(nm, t0, er, edz);
  endtask

  initial begin
    int  t0;
    bit  seen;
    reset = 1'b1; start = 1'b0; op1 = '0; op2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_div_zero", {31'b0, div_zero}, 32'd0);
    reset = 1'b0;

    run_op("six_by_two",   32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
    run_op("one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0);
    run_op("neg_six",      32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0);
    run_op("one_by_zero",  32'h3F800000, 32'h00000000, 32'h7F7FFFFF, 1'b1);
    run_op("zero_by_zero", 32'h00000000, 32'h00000000, 32'h7F7FFFFF, 1'b1);
    run_op("overflow",     32'h7F000000, 32'h3E800000, 32'h7F7FFFFF, 1'b0);
    run_op("underflow",    32'h00800000, 32'h40000000, 32'h00000000, 1'b0);
    run_op("neg_zero",     32'h80000000, 32'h40000000, 32'h80000000, 1'b0);
    run_op("neg_by_zero",  32'hBF800000, 32'h00000000, 32'hFF7FFFFF, 1'b1);
    run_op("seven_by_half",32'h40E00000, 32'h3F000000, 32'h41600000, 1'b0);

    // Start while busy is ignored; operands changed mid-flight do not matter
    @(negedge clk);
    op1 = 32'h40C00000; op2 = 32'h40000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    repeat (4) @(negedge clk);
    op1 = 32'h3F800000; op2 = 32'h40400000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_ignore", t0, 32'h40400000, 1'b0);

    // Back-to-back: new start during the done cycle
    op1 = 32'h3F800000; op2 = 32'h40400000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    wait_done("back_to_back", t0, 32'h3EAAAAAA, 1'b0);

    // Reset 10 cycles into an operation
    @(negedge clk);
    op1 = 32'h40C00000; op2 = 32'h40000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_result", result, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    chk("mid_rst_no_done", {31'b0, seen}, 32'd0);

    // Reset wins over start in the same cycle
    @(negedge clk);
    reset = 1'b1; start = 1'b1; op1 = 32'h40C00000; op2 = 32'h40000000;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("rst_prio_busy", {31'b0, busy}, 32'd0);
    repeat (30) @(negedge clk);

    run_op("after_reset", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/float_div.md
FLOAT_DIV -- requirements
Module: float_div

Interface
REQ-001 SHALL have parameter N_mantisse, default 23, mantissa field width (1..23).
REQ-002 SHALL have parameter N_exposant, default 8, exponent field width (2..8); W = 1+N_exposant+N_mantisse below.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port op1  input  W  dividend, packed {signe, exposant MSB-first, mantisse}.
REQ-007 SHALL have port op2  input  W  divisor, same packing.
REQ-008 SHALL have port busy  output  1  high while an operation is in flight.
REQ-009 SHALL have port done  output  1  single-cycle pulse, result valid.
REQ-010 SHALL have port result  output  W  quotient, same packing, held until next done.
REQ-011 SHALL have port div_zero  output  1  op2 was zero, updated with done.

Function
REQ-012 SHALL use the float_pack format: bias D_e = 2^(N_exposant-1)-1, implicit leading 1, exponent 0 means zero, no denormals/NaN/Inf.
REQ-013 SHALL implement FSM IDLE -> DIVIDE -> NORM -> IDLE; start=1 in IDLE at edge k captures op1/op2, enters DIVIDE.
REQ-014 SHALL ignore start when not IDLE; captured operands unaffected by later op1/op2 changes.
REQ-015 SHALL compute mantissa quotient by restoring division of {1,m1} by {1,m2}, one quotient bit per DIVIDE cycle, N_mantisse+2 cycles.
REQ-016 SHALL, in NORM: if quotient MSB=0, shift left one and subtract 1 from exponent; mantissa = next N_mantisse bits below leading 1; remaining bits truncated (no rounding).
REQ-017 SHALL compute exponent in signed N_exposant+2 bits as e1 - e2 + D_e - norm_shift.
REQ-018 SHALL set result sign = op1.signe XOR op2.signe in all cases, including zero and saturation.
REQ-019 SHALL, if op2 exponent = 0: result exponent = 2^N_exposant-2, mantissa all ones, div_zero=1 (precedence over op1 zero).
REQ-020 SHALL, if op1 exponent = 0 (op2 nonzero), or computed exponent < 1: result exponent 0, mantissa 0.
REQ-021 SHALL, if computed exponent > 2^N_exposant-2: saturate to exponent 2^N_exposant-2, mantissa all ones, div_zero=0.
REQ-022 SHALL have fixed latency regardless of operands: busy=1 after edges k+1..k+N_mantisse+3; result/div_zero/done update at edge k+N_mantisse+3; done=1 for that one cycle only; busy=0 and FSM in IDLE after edge k+N_mantisse+4.
REQ-023 SHALL accept a new start in the cycle done is high (back-to-back), 0 idle cycles between operations.

Reset
REQ-024 SHALL, on reset=1 at a rising edge, go to IDLE and set busy=0, done=0, div_zero=0, result=0, regardless of state.
REQ-025 SHALL discard an in-flight operation on reset; no done pulse for it afterwards.
REQ-026 SHALL give reset priority over start in the same cycle.

Verification (N_exposant=8, N_mantisse=23)
REQ-027 SHALL cover 0x40C00000 / 0x40000000 (6.0/2.0) -> result 0x40400000, done exactly 26 cycles after start edge, div_zero=0.
REQ-028 SHALL cover 0x3F800000 / 0x40400000 (1.0/3.0) -> 0x3EAAAAAA (truncated, normalization path), and 0xC0C00000 / 0x40000000 -> 0xC0400000.
REQ-029 SHALL cover 0x3F800000 / 0x00000000 -> 0x7F7FFFFF, div_zero=1; 0x00000000 / 0x00000000 -> 0x7F7FFFFF, div_zero=1.
REQ-030 SHALL cover overflow 0x7F000000 / 0x3E800000 -> 0x7F7FFFFF, and underflow 0x00800000 / 0x40000000 -> 0x00000000.
REQ-031 SHALL cover start pulsed while busy (ignored, first result unchanged) and back-to-back start during done (second done 26 cycles later).
REQ-032 SHALL cover reset asserted 10 cycles into an operation -> busy=0, result=0 next cycle, no done within 40 following cycles.
